video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CW, default 12: width of timing counters, config fields and coordinates.
REQ-002 Parameter DW, default 24: pixel colour width.
REQ-003 Parameter REQ_LAT, default 2, legal 1..4: clocks from data_req to the matching video_de.
REQ-004 Parameter HS_POL, default 0: level of video_hs during the sync pulse (0 = active-low).
REQ-005 Parameter VS_POL, default 0: level of video_vs during the sync pulse.
REQ-006 pixel_clk  input  1  pixel clock; all logic is on the rising edge.
REQ-007 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-008 cfg_valid  input  1  new timing set offered.
REQ-009 cfg_ready  output  1  block can accept a timing set.
REQ-010 cfg_hs  input  CW  horizontal sync width (clocks).
REQ-011 cfg_hb  input  CW  horizontal back porch.
REQ-012 cfg_hd  input  CW  horizontal active pixels.
REQ-013 cfg_ht  input  CW  horizontal total.
REQ-014 cfg_vs  input  CW  vertical sync width (lines).
REQ-015 cfg_vb  input  CW  vertical back porch.
REQ-016 cfg_vd  input  CW  vertical active lines.
REQ-017 cfg_vt  input  CW  vertical total.
REQ-018 cfg_err  output  1  one-cycle pulse when a rejected set is discarded.
REQ-019 data_req  output  1  pixel request; pixel_data is due REQ_LAT clocks later.
REQ-020 pixel_xpos  output  CW  x of the requested pixel.
REQ-021 pixel_ypos  output  CW  y of the requested pixel.
REQ-022 frame_start  output  1  pulse with the first data_req of each frame.
REQ-023 pixel_data  input  DW  pixel colour, REQ_LAT clocks after its data_req.
REQ-024 video_hs  output  1  horizontal sync.
REQ-025 video_vs  output  1  vertical sync.
REQ-026 video_de  output  1  data enable.
REQ-027 video_rgb  output  DW  colour out.

Function
REQ-028 Counters:
- cnt_h counts 0..ht-1, then wraps to 0.
- cnt_v increments when cnt_h==ht-1 and wraps to 0 after vt-1.
- Timing comes from the active register set.
REQ-029 Active window: cnt_h in [hs+hb, hs+hb+hd) and cnt_v in [vs+vb, vs+vb+vd).
- Window sums are computed in CW+1 bits so they cannot overflow.
REQ-030 data_req is a register, set the cycle after the counters are inside the active window.
REQ-031 Coordinates are registered on the same cycle as data_req:
- pixel_xpos = cnt_h-(hs+hb) while data_req, else 0.
- pixel_ypos = cnt_v-(vs+vb) during active lines, else 0.
REQ-032 Sync and enable alignment:
- video_de is data_req delayed by exactly REQ_LAT registers.
- video_hs is (cnt_h<hs ? HS_POL : !HS_POL), taken at the data_req stage and delayed by the same REQ_LAT registers.
- video_vs is derived from cnt_v and VS_POL in the same way.
REQ-033 video_rgb = video_de ? pixel_data : 0, combinational.
REQ-034 frame_start is high exactly on the cycle data_req is high with x=0 and y=0.
REQ-035 Config handshake, capture:
- A set is captured into a pending register when cfg_valid&&cfg_ready.
- cfg_ready drops the next cycle.
- cfg_valid while cfg_ready=0 is ignored.
REQ-036 Config handshake, apply:
- The pending set is applied at the frame boundary (cnt_h==ht-1 && cnt_v==vt-1).
- Counters restart at 0 under the new timing.
- cfg_ready returns to 1 on the next cycle.
- A set captured on a boundary cycle is applied at the following boundary, not the current one.
REQ-037 Rejection:
- A pending set is rejected at apply time if hs+hb+hd>ht, vs+vb+vd>vt, ht<2 or vt<2.
- On rejection, cfg_err pulses, the active timing is unchanged and cfg_ready returns to 1.
REQ-038 If hd=0 or vd=0 (and the set is otherwise valid), data_req, video_de and frame_start stay 0 while syncs keep running.

Reset
REQ-039 Reset state:
- Outputs: data_req, video_de, frame_start, cfg_err, coordinates and the delay pipeline go to 0.
- video_hs resets to !HS_POL and video_vs to !VS_POL.
- cfg_ready resets to 1.
- Counters go to 0, the pending set is cleared and the active set loads the package defaults.
REQ-040 Reset takes effect immediately at any point in a frame. After release, the first pixel_clk edge counts from cnt_h=cnt_v=0.

Structure
REQ-041 A shared package holds:
- default timing constants: H 128/88/800/1056, V 3/21/480/505;
- the timing-record typedef (eight CW fields);
- the REQ_LAT bounds.
REQ-042 One sub-module, video_delay_line (parameterised width and depth), implements the REQ_LAT alignment pipeline for de, hs and vs.

Verification
REQ-043 Defaults after reset, HS_POL=0 -> per line: hs low 128 clocks of 1056 and de high 800 clocks; per frame: vs low 3 lines of 505 and 480 de lines; frame_start once per frame.
REQ-044 Config hs2/hb2/hd4/ht10 and vs1/vb1/vd3/vt6, REQ_LAT=2, pixel_data = xpos delayed 2 -> per line: xpos 0,1,2,3; de rises 2 clocks after data_req; rgb 0,1,2,3; ypos 0..2.
REQ-045 Config offered mid-frame -> cfg_ready low until the boundary, new timing from the next cnt 0; a second cfg_valid while pending is ignored.
REQ-046 Invalid set hs2/hb2/hd9/ht10 -> one cfg_err pulse at the boundary, timing unchanged, cfg_ready back to 1.
REQ-047 sys_rst_n low during an active line -> data_req, de and rgb go to 0 immediately; after release, defaults restart from cnt 0.
REQ-048 HS_POL=1, VS_POL=1 -> hs high for hs clocks and vs high for vs lines; idle levels are low.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared timing definitions for the video timing generator: default mode,
// the timing record and the legal range of the request-to-enable latency.
package video_timing_gen_pkg;

    localparam int TIMING_CW   = 12;
    localparam int REQ_LAT_MIN = 1;
    localparam int REQ_LAT_MAX = 4;

    typedef struct packed {
        logic [TIMING_CW-1:0] hs;
        logic [TIMING_CW-1:0] hb;
        logic [TIMING_CW-1:0] hd;
        logic [TIMING_CW-1:0] ht;
        logic [TIMING_CW-1:0] vs;
        logic [TIMING_CW-1:0] vb;
        logic [TIMING_CW-1:0] vd;
        logic [TIMING_CW-1:0] vt;
    } timing_t;

    localparam timing_t TIMING_DEFAULT = '{
        hs: TIMING_CW'(128), hb: TIMING_CW'(88), hd: TIMING_CW'(800), ht: TIMING_CW'(1056),
        vs: TIMING_CW'(3),   vb: TIMING_CW'(21), vd: TIMING_CW'(480), vt: TIMING_CW'(505)
    };

    // Three-term sums get two extra bits so a hostile set cannot wrap past the total.
    function automatic logic timing_ok(input timing_t t);
        logic [TIMING_CW+1:0] h_sum;
        logic [TIMING_CW+1:0] v_sum;
        h_sum = {2'b00, t.hs} + {2'b00, t.hb} + {2'b00, t.hd};
        v_sum = {2'b00, t.vs} + {2'b00, t.vb} + {2'b00, t.vd};
        return (h_sum <= {2'b00, t.ht}) && (v_sum <= {2'b00, t.vt}) &&
               (t.ht >= TIMING_CW'(2)) && (t.vt >= TIMING_CW'(2));
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth register pipeline aligning sync/enable with the pixel fetch latency.
module video_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         pixel_clk,
    input  logic         sys_rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel requests ahead of the display, sync/enable
// realigned to the fetch latency, and frame-synchronous timing reconfiguration.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int      CW         = 12,
    parameter int      DW         = 24,
    parameter int      REQ_LAT    = 2,
    parameter bit      HS_POL     = 1'b0,
    parameter bit      VS_POL     = 1'b0,
    parameter timing_t RST_TIMING = TIMING_DEFAULT
) (
    input  logic          pixel_clk,
    input  logic          sys_rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_hs,
    input  logic [CW-1:0] cfg_hb,
    input  logic [CW-1:0] cfg_hd,
    input  logic [CW-1:0] cfg_ht,
    input  logic [CW-1:0] cfg_vs,
    input  logic [CW-1:0] cfg_vb,
    input  logic [CW-1:0] cfg_vd,
    input  logic [CW-1:0] cfg_vt,
    output logic          cfg_err,
    output logic          data_req,
    output logic [CW-1:0] pixel_xpos,
    output logic [CW-1:0] pixel_ypos,
    output logic          frame_start,
    input  logic [DW-1:0] pixel_data,
    output logic          video_hs,
    output logic          video_vs,
    output logic          video_de,
    output logic [DW-1:0] video_rgb
);

    localparam int LAT = (REQ_LAT < REQ_LAT_MIN) ? REQ_LAT_MIN :
                         (REQ_LAT > REQ_LAT_MAX) ? REQ_LAT_MAX : REQ_LAT;

    timing_t       act_q, act_d;
    timing_t       pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          cfg_err_q, cfg_err_d;
    logic [CW-1:0] cnt_h_q, cnt_h_d;
    logic [CW-1:0] cnt_v_q, cnt_v_d;
    logic          data_req_q, data_req_d;
    logic [CW-1:0] xpos_q, xpos_d;
    logic [CW-1:0] ypos_q, ypos_d;
    logic          fs_q, fs_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic [CW:0]   h_start, h_end, v_start, v_end;
    logic [CW:0]   x_diff, y_diff;
    logic          h_last, v_last, in_h, in_v;
    logic [2:0]    dly_out;

    always_comb begin
        h_start = {1'b0, act_q.hs} + {1'b0, act_q.hb};
        h_end   = h_start + {1'b0, act_q.hd};
        v_start = {1'b0, act_q.vs} + {1'b0, act_q.vb};
        v_end   = v_start + {1'b0, act_q.vd};
        h_last  = (cnt_h_q >= act_q.ht - CW'(1));
        v_last  = (cnt_v_q >= act_q.vt - CW'(1));
        in_h    = ({1'b0, cnt_h_q} >= h_start) && ({1'b0, cnt_h_q} < h_end);
        in_v    = ({1'b0, cnt_v_q} >= v_start) && ({1'b0, cnt_v_q} < v_end);
        x_diff  = {1'b0, cnt_h_q} - h_start;
        y_diff  = {1'b0, cnt_v_q} - v_start;

        cnt_h_d = h_last ? '0 : cnt_h_q + CW'(1);
        cnt_v_d = cnt_v_q;
        if (h_last) begin
            cnt_v_d = v_last ? '0 : cnt_v_q + CW'(1);
        end

        // A new set only takes over on the last pixel of a frame, so the
        // counters naturally restart at zero under it.
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = 1'b0;
        if (h_last && v_last && pend_vld_q) begin
            pend_vld_d = 1'b0;
            if (timing_ok(pend_q)) begin
                act_d = pend_q;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (cfg_valid && !pend_vld_q) begin
            pend_d     = '{hs: cfg_hs, hb: cfg_hb, hd: cfg_hd, ht: cfg_ht,
                           vs: cfg_vs, vb: cfg_vb, vd: cfg_vd, vt: cfg_vt};
            pend_vld_d = 1'b1;
        end

        data_req_d = in_h && in_v;
        xpos_d     = data_req_d ? x_diff[CW-1:0] : '0;
        ypos_d     = in_v ? y_diff[CW-1:0] : '0;
        fs_d       = data_req_d && (xpos_d == '0) && (ypos_d == '0);
        hs_d       = (cnt_h_q < act_q.hs) ? HS_POL : !HS_POL;
        vs_d       = (cnt_v_q < act_q.vs) ? VS_POL : !VS_POL;
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_q      <= RST_TIMING;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            cnt_h_q    <= '0;
            cnt_v_q    <= '0;
            data_req_q <= 1'b0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            fs_q       <= 1'b0;
            hs_q       <= !HS_POL;
            vs_q       <= !VS_POL;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
            cnt_h_q    <= cnt_h_d;
            cnt_v_q    <= cnt_v_d;
            data_req_q <= data_req_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            fs_q       <= fs_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    // Syncs are sampled alongside data_req so all three share the fetch latency.
    video_delay_line #(
        .W       (3),
        .DEPTH   (LAT),
        .RST_VAL ({~VS_POL, ~HS_POL, 1'b0})
    ) u_delay (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .din       ({vs_q, hs_q, data_req_q}),
        .dout      (dly_out)
    );

    assign cfg_ready   = !pend_vld_q;
    assign cfg_err     = cfg_err_q;
    assign data_req    = data_req_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = fs_q;
    assign video_de    = dly_out[0];
    assign video_hs    = dly_out[1];
    assign video_vs    = dly_out[2];
    assign video_rgb   = video_de ? pixel_data : '0;

endmodule
